// File: rtl/sync_fifo_prm_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_prm_pkg
// Shared definitions for the sync_fifo_prm FIFO:
//   - 4-bit fill/free-space flag codes
//   - flag_enc(): maps a count onto the flag code for a FIFO of a given depth
//   - fifo_stat_t: registered status bundle (flags + almost thresholds)
// -----------------------------------------------------------------------------
package sync_fifo_prm_pkg;

  // FLG_EMPTY and FLG_FULL share a code: "nothing there". It means empty on
  // the fill side (POP_FLAG) and no room left on the free side (PUSH_FLAG).
  localparam logic [3:0] FLG_EMPTY = 4'h0;
  localparam logic [3:0] FLG_FULL  = 4'h0;
  localparam logic [3:0] FLG_ONE   = 4'h1;
  localparam logic [3:0] FLG_LOW   = 4'h2;
  localparam logic [3:0] FLG_Q1    = 4'h3;
  localparam logic [3:0] FLG_Q2    = 4'h4;
  localparam logic [3:0] FLG_ALL   = 4'h8;

  typedef struct packed {
    logic [3:0] pop_flag;   // fill code
    logic [3:0] push_flag;  // free-space code
    logic       afull;
    logic       aempty;
  } fifo_stat_t;

  // Count c is either a fill level or a free-space amount, 0..depth.
  // For small depths some bands are empty (depth=8: LOW never occurs).
  function automatic logic [3:0] flag_enc(input int c, input int depth);
    if (c == 0)                flag_enc = FLG_EMPTY;
    else if (c == 1)           flag_enc = FLG_ONE;
    else if (c < depth / 4)    flag_enc = FLG_LOW;
    else if (c < depth / 2)    flag_enc = FLG_Q1;
    else if (c < depth)        flag_enc = FLG_Q2;
    else                       flag_enc = FLG_ALL;
  endfunction

endpackage

// File: rtl/sync_fifo_prm_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_prm_ram
// DATA_W x DEPTH storage, one write port, one synchronous read port.
//   clk_i    clock
//   rst_i    synchronous reset of the read data register only (array untouched)
//   we_i     write enable, waddr_i / wdata_i write address / data
//   re_i     read enable, raddr_i read address
//   rdata_o  registered read data, held while re_i is low
// A read and a write to the same address on one edge return the old word;
// the FIFO relies on this when it pushes and pops a full buffer together.
// -----------------------------------------------------------------------------
module sync_fifo_prm_ram
  import sync_fifo_prm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_prm.sv
// -----------------------------------------------------------------------------
// sync_fifo_prm
// Single-clock FIFO with programmable almost thresholds, coarse fill and
// free-space flags, and sticky overflow/underflow errors.
//   Fifo_Clk      clock, all state on rising edge
//   Fifo_Rst      synchronous active-high reset, beats flush/push/pop
//   Fifo_Flush    synchronous flush: empties, clears errors, DOUT held
//   PUSH / DIN    write request / data
//   POP / DOUT    read request / data (DOUT loaded at the pop edge)
//   Level         fill count 0..DEPTH
//   PUSH_FLAG     free-space code, POP_FLAG fill code (see flag_enc)
//   Almost_Full   Level >= AF_LEVEL, Almost_Empty Level <= AE_LEVEL
//   Overflow      sticky: push refused while full
//   Underflow     sticky: pop while empty
// Build option: SYNC_FIFO_PRM_REG_RD_EN adds an output register after the
// RAM read port, making pop-to-DOUT two edges instead of one. Status outputs
// are unaffected.
// -----------------------------------------------------------------------------
module sync_fifo_prm
  import sync_fifo_prm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 512,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = AW + 1
) (
  input  logic              Fifo_Clk,
  input  logic              Fifo_Rst,
  input  logic              Fifo_Flush,
  input  logic              PUSH,
  input  logic [DATA_W-1:0] DIN,
  input  logic              POP,
  output logic [DATA_W-1:0] DOUT,
  output logic [LW-1:0]     Level,
  output logic [3:0]        PUSH_FLAG,
  output logic [3:0]        POP_FLAG,
  output logic              Almost_Full,
  output logic              Almost_Empty,
  output logic              Overflow,
  output logic              Underflow
);

  localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  fifo_stat_t    stat_q, stat_d;
  logic          pop_acc, push_acc, ram_we, ram_re;
  logic [DATA_W-1:0] ram_dout;

  // A full FIFO still takes a push when the same edge pops: the pop frees
  // the slot the push lands in.
  assign pop_acc  = POP  && (cnt_q != '0);
  assign push_acc = PUSH && ((cnt_q != FULL_CNT) || pop_acc);

  // Storage must see neither flush-shadowed nor reset-shadowed traffic so
  // that DOUT holds across a flush and reads zero after reset.
  assign ram_we = push_acc && !Fifo_Flush && !Fifo_Rst;
  assign ram_re = pop_acc  && !Fifo_Flush && !Fifo_Rst;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (Fifo_Flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else begin
      if (push_acc) wptr_d = wptr_q + AW'(1);
      if (pop_acc)  rptr_d = rptr_q + AW'(1);
      case ({push_acc, pop_acc})
        2'b10:   cnt_d = cnt_q + LW'(1);
        2'b01:   cnt_d = cnt_q - LW'(1);
        default: cnt_d = cnt_q;
      endcase
      ovf_d = ovf_q || (PUSH && !push_acc);
      unf_d = unf_q || (POP  && !pop_acc);
    end
  end

  // Status is derived from the next count and registered with it, so the
  // flags always describe the Level being presented in the same cycle.
  always_comb begin
    stat_d.pop_flag  = flag_enc(int'(cnt_d), DEPTH);
    stat_d.push_flag = flag_enc(DEPTH - int'(cnt_d), DEPTH);
    stat_d.afull     = int'(cnt_d) >= AF_LEVEL;
    stat_d.aempty    = int'(cnt_d) <= AE_LEVEL;
  end

  always_ff @(posedge Fifo_Clk) begin
    if (Fifo_Rst) begin
      wptr_q           <= '0;
      rptr_q           <= '0;
      cnt_q            <= '0;
      ovf_q            <= 1'b0;
      unf_q            <= 1'b0;
      stat_q.pop_flag  <= FLG_EMPTY;
      stat_q.push_flag <= FLG_ALL;
      stat_q.afull     <= 1'b0;
      stat_q.aempty    <= 1'b1;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      stat_q <= stat_d;
    end
  end

  sync_fifo_prm_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (Fifo_Clk),
    .rst_i   (Fifo_Rst),
    .we_i    (ram_we),
    .waddr_i (wptr_q),
    .wdata_i (DIN),
    .re_i    (ram_re),
    .raddr_i (rptr_q),
    .rdata_o (ram_dout)
  );

`ifdef SYNC_FIFO_PRM_REG_RD_EN
  // Free-running copy of the read port: the RAM output already holds between
  // pops, so re-sampling it every edge simply adds one edge of latency.
  logic [DATA_W-1:0] dout_q;
  always_ff @(posedge Fifo_Clk) begin
    if (Fifo_Rst) dout_q <= '0;
    else          dout_q <= ram_dout;
  end
  assign DOUT = dout_q;
`else
  assign DOUT = ram_dout;
`endif

  assign Level        = cnt_q;
  assign POP_FLAG     = stat_q.pop_flag;
  assign PUSH_FLAG    = stat_q.push_flag;
  assign Almost_Full  = stat_q.afull;
  assign Almost_Empty = stat_q.aempty;
  assign Overflow     = ovf_q;
  assign Underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_prm.sv
module tb_sync_fifo_prm;
  localparam int DW = 32, D = 16, AF = 12, AE = 4;

  logic          Fifo_Clk = 1'b0, Fifo_Rst = 1'b1, Fifo_Flush = 1'b0;
  logic          PUSH = 1'b0, POP = 1'b0;
  logic [DW-1:0] DIN = '0, DOUT;
  logic [4:0]    Level;
  logic [3:0]    PUSH_FLAG, POP_FLAG;
  logic          Almost_Full, Almost_Empty, Overflow, Underflow;

  sync_fifo_prm #(.DATA_W(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .Fifo_Clk(Fifo_Clk), .Fifo_Rst(Fifo_Rst), .Fifo_Flush(Fifo_Flush),
    .PUSH(PUSH), .DIN(DIN), .POP(POP), .DOUT(DOUT), .Level(Level),
    .PUSH_FLAG(PUSH_FLAG), .POP_FLAG(POP_FLAG), .Almost_Full(Almost_Full),
    .Almost_Empty(Almost_Empty), .Overflow(Overflow), .Underflow(Underflow));

  always #5 Fifo_Clk = ~Fifo_Clk;

  int checks = 0, errors = 0;

  // reference model: a queue plus sticky bits and the last popped word
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0, m_dout_d = '0;
  bit m_ovf = 0, m_unf = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_code(input int c);
    if (c == D)            return 4'h8;
    else if (c >= D / 2)   return 4'h4;
    else if (c >= D / 4)   return 4'h3;
    else if (c >= 2)       return 4'h2;
    else                   return 4'(c);
  endfunction

  task automatic model(input bit r, f, pu, po, input logic [DW-1:0] d);
    logic [DW-1:0] prev;
    bit pa, ua;
    prev = m_dout;
    if (r) begin
      mq.delete(); m_dout = '0; prev = '0; m_ovf = 0; m_unf = 0;
    end else if (f) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      pa = po && mq.size() > 0;
      ua = pu && (mq.size() < D || pa);
      if (po && !pa) m_unf = 1;
      if (pu && !ua) m_ovf = 1;
      if (pa) m_dout = mq.pop_front();
      if (ua) mq.push_back(d);
    end
    m_dout_d = prev;
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("level", Level, n);
    chk("pop_flag", POP_FLAG, ref_code(n));
    chk("push_flag", PUSH_FLAG, ref_code(D - n));
    chk("almost_full", Almost_Full, n >= AF);
    chk("almost_empty", Almost_Empty, n <= AE);
    chk("overflow", Overflow, m_ovf);
    chk("underflow", Underflow, m_unf);
`ifdef SYNC_FIFO_PRM_REG_RD_EN
    chk("dout", DOUT, m_dout_d);
`else
    chk("dout", DOUT, m_dout);
`endif
  endtask

  task automatic step(input bit r, f, pu, po, input logic [DW-1:0] d);
    Fifo_Rst = r; Fifo_Flush = f; PUSH = pu; POP = po; DIN = d;
    @(posedge Fifo_Clk);
    model(r, f, pu, po, d);
    @(negedge Fifo_Clk);
    check_all();
  endtask

  typedef struct {
    bit r, f, pu, po;
    logic [DW-1:0] din;
    int lvl;
    logic [3:0] popf, pushf;
    bit ovf, unf;
    logic [DW-1:0] dout;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1,0,0,0,32'h0,  0, 4'h0, 4'h8, 0, 0, 32'h0};
    tbl[1] = '{0,0,0,1,32'h0,  0, 4'h0, 4'h8, 0, 1, 32'h0};
    tbl[2] = '{0,0,1,0,32'h11, 1, 4'h1, 4'h4, 0, 1, 32'h0};
    tbl[3] = '{0,0,1,0,32'h22, 2, 4'h2, 4'h4, 0, 1, 32'h0};
    tbl[4] = '{0,0,0,1,32'h0,  1, 4'h1, 4'h4, 0, 1, 32'h11};
    tbl[5] = '{0,0,1,1,32'h33, 1, 4'h1, 4'h4, 0, 1, 32'h22};
    tbl[6] = '{0,1,1,0,32'h44, 0, 4'h0, 4'h8, 0, 0, 32'h22};
    tbl[7] = '{0,0,0,1,32'h0,  0, 4'h0, 4'h8, 0, 1, 32'h22};
    tbl[8] = '{1,0,0,0,32'h0,  0, 4'h0, 4'h8, 0, 0, 32'h0};

    @(negedge Fifo_Clk);

    // table-driven basics
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].f, tbl[i].pu, tbl[i].po, tbl[i].din);
      chk($sformatf("tbl%0d_level", i), Level, tbl[i].lvl);
      chk($sformatf("tbl%0d_popf", i), POP_FLAG, tbl[i].popf);
      chk($sformatf("tbl%0d_pushf", i), PUSH_FLAG, tbl[i].pushf);
      chk($sformatf("tbl%0d_ovf", i), Overflow, tbl[i].ovf);
      chk($sformatf("tbl%0d_unf", i), Underflow, tbl[i].unf);
`ifndef SYNC_FIFO_PRM_REG_RD_EN
      chk($sformatf("tbl%0d_dout", i), DOUT, tbl[i].dout);
`endif
    end
    chk("reset_aempty", Almost_Empty, 1'b1);
    chk("reset_afull", Almost_Full, 1'b0);

    // fill to full, almost-full edge, overflow
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 0, i);
      if (i == 11) chk("afull_at11", Almost_Full, 1'b0);
      if (i == 12) chk("afull_at12", Almost_Full, 1'b1);
    end
    chk("full_level", Level, 16);
    chk("full_popf", POP_FLAG, 4'h8);
    chk("full_pushf", PUSH_FLAG, 4'h0);
    step(0, 0, 1, 0, 32'h17);
    chk("ovf_set", Overflow, 1'b1);
    chk("ovf_level", Level, 16);

    // full push+pop, drain, underflow
    step(0, 0, 1, 1, 32'hAA);
    chk("fullpp_level", Level, 16);
    chk("fullpp_ovf", Overflow, 1'b1);
    step(0, 0, 0, 0, 0);
    chk("fullpp_dout", DOUT, 32'h1);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
    chk("drained_unf", Underflow, 1'b0);
    step(0, 0, 0, 1, 0);
    chk("unf_set", Underflow, 1'b1);
    chk("drain_last", DOUT, 32'hAA);

    // order across wrap: bursts of 16/16/8 with level swinging 0..16
    step(1, 0, 0, 0, 0);
    begin
      int k, bl[3];
      k = 0; bl = '{16, 16, 8};
      for (int b = 0; b < 3; b++) begin
        for (int j = 0; j < bl[b]; j++) begin step(0, 0, 1, 0, 32'h100 + k); k++; end
        for (int j = 0; j < bl[b]; j++) step(0, 0, 0, 1, 0);
      end
      step(0, 0, 0, 0, 0);
      chk("wrap_last", DOUT, 32'h100 + 39);
      chk("wrap_empty", Level, 0);
    end

    // flush with push, errors cleared; reset mid-stream
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 32'h200 + i);
    chk("pre_flush_level", Level, 9);
    step(0, 1, 1, 0, 32'hDEAD);
    chk("flush_level", Level, 0);
    chk("flush_ovf", Overflow, 1'b0);
    chk("flush_unf", Underflow, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 32'h300 + i);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 32'h305);
    chk("pre_rst_level", Level, 5);
    step(1, 1, 1, 1, 32'hBEEF);
    chk("rst_level", Level, 0);
    chk("rst_pushf", PUSH_FLAG, 4'h8);
    chk("rst_dout", DOUT, 32'h0);

    // pop-to-DOUT latency
    step(0, 0, 1, 0, 32'h55);
    step(0, 0, 0, 1, 0);
`ifdef SYNC_FIFO_PRM_REG_RD_EN
    chk("lat_edge1", DOUT, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("lat_edge2", DOUT, 32'h55);
`else
    chk("lat_edge1", DOUT, 32'h55);
`endif

    // randomized traffic with phase-varying push/pop bias
    for (int i = 0; i < 3000; i++) begin
      int pp, rp;
      pp = ((i / 200) % 2) ? 30 : 70;
      rp = ((i / 200) % 2) ? 70 : 30;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < pp, $urandom_range(0, 99) < rp, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
